pmm_match_engine: RTL and testbench
===================================

Name: pmm_match_engine

Overview:
- Per-module pattern-matching engine: the module-side end of the pattern-matching peripheral's data/control channel.
- Receives a 64-bit data word, a 16-bit control word and a data_ready level from the CPU-facing interface, and executes the operation.
- Returns data_accepted (four-phase handshake) and a sticky pattern_accepted flag.
- One instance per module slot; outputs feed the interface's data_accepted/pattern_accepted bit vectors.

Parameters:
- MAX_PAT_LEN, 8, maximum pattern length and history depth in bytes; must be ≤ 8, since a data word carries 8 bytes.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pmp_data  input  64  data word; byte i = pmp_data[8i+7:8i]; byte 0 is first in stream/pattern order
- pmp_control  input  16  [15:14] opcode (00 NOP, 01 LOAD_PATTERN, 10 STREAM_DATA, 11 CLEAR); [13:10] byte count; [9:0] reserved, ignored
- data_ready  input  1  level; high = operation pending; pmp_data/pmp_control stable while high
- data_accepted  output  1  high = operation complete; held until data_ready falls
- pattern_accepted  output  1  sticky: pattern seen in stream since last LOAD/CLEAR
- busy  output  1  high in SCAN state

Behaviour:
- Reset (asynchronous, any time, including mid-SCAN):
  - state = IDLE.
  - data_accepted = 0, pattern_accepted = 0, busy = 0.
  - Pattern, pat_len, history, fill count and byte index all cleared.
- States: IDLE, SCAN, DONE.
- IDLE, data_ready=1 at edge k: capture data and control. Count is clipped to MAX_PAT_LEN.
  - NOP, or STREAM with count 0: go to DONE at edge k, no side effects.
  - LOAD_PATTERN: at edge k, pattern <= data bytes 0..count-1 and pat_len <= count. Clear history, fill count and pattern_accepted. Go to DONE.
    - LOAD with count 0 sets pat_len = 0; with pat_len = 0 nothing ever matches.
  - CLEAR: at edge k, clear history, fill count and pattern_accepted. Pattern is kept. Go to DONE.
  - STREAM_DATA with count n > 0: go to SCAN at edge k with idx = 0.
- SCAN: one byte per cycle. At edges k+1 .. k+n, process byte idx:
  - Shift the byte into history; history[0] = newest byte.
  - Fill count increments, saturating at MAX_PAT_LEN.
  - idx increments.
- Match rule, evaluated on each shifted byte: pat_len > 0, fill ≥ pat_len, and history[i] == pattern[pat_len-1-i] for all i < pat_len.
  - Compare uses the post-shift history.
  - On a match, pattern_accepted <= 1 at the same edge.
  - Overlapping matches are legal.
  - History persists across STREAM operations, so matches may span data words.
- After the byte at edge k+n: go to DONE. STREAM latency is n cycles to data_accepted.
- DONE:
  - data_accepted = 1 while data_ready = 1.
  - When data_ready = 0 at a clock edge: data_accepted <= 0, go to IDLE.
  - A new operation is accepted no earlier than the edge after return to IDLE.
- data_ready falling during SCAN is a protocol violation. The scan still completes all n bytes, then goes to DONE and immediately to IDLE on the next edge. data_accepted is asserted for at most one cycle.
- pattern_accepted changes only on a match (set) or on LOAD/CLEAR/reset (clear).
- Changes to pmp_data/pmp_control during SCAN/DONE are ignored; the captured copies are used.

Optional Feature:
- Macro: PMM_MATCH_COUNT_EN.
- Defined:
  - Adds output match_count[15:0], reset 0.
  - Increments once per matching byte and saturates at 0xFFFF.
  - Cleared by LOAD, CLEAR and reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Load pattern "AB": ctrl 0x4800, data 0x4241, ready=1 → data_accepted=1 after 1 edge, pattern_accepted=0. Drop ready → data_accepted=0 next edge.
- Stream "xxAB": ctrl 0x9000, data 0x42417878 → busy for 4 cycles; pattern_accepted rises at the 4th SCAN edge; data_accepted after 4 cycles. With PMM_MATCH_COUNT_EN: match_count=1.
- Cross-word match: stream "zA" (ctrl 0x8800, data 0x417A), handshake, then stream "Bz" (ctrl 0x8800, data 0x7A42) → pattern_accepted rises at the 1st SCAN edge of the second word.
- Overlap: load "AA" (0x4800, 0x4141), stream "AAA" (0x8C00, 0x414141) → pattern_accepted=1; match_count=2 when the feature is enabled. Then CLEAR (0xC000) → pattern_accepted=0, match_count=0, pattern retained: re-stream "AA" matches.
- Edge cases:
  - Count 12 is clipped to 8 bytes (8 SCAN cycles).
  - STREAM with count 0 → DONE after 1 edge.
  - LOAD with count 0 → never matches.
- Reset asserted at the 2nd SCAN cycle, asynchronously → all outputs 0 immediately. After release, streaming "AB" without a reload does not match (pat_len=0).

Source files
------------

// File: rtl/pmm_match_engine_if.sv
// Data/control channel between the CPU-facing interface and one match engine.
// match_count is present only when PMM_MATCH_COUNT_EN is defined.
interface pmm_match_engine_if;
  logic [63:0] pmp_data;
  logic [15:0] pmp_control;
  logic        data_ready;
  logic        data_accepted;
  logic        pattern_accepted;
  logic        busy;
`ifdef PMM_MATCH_COUNT_EN
  logic [15:0] match_count;

  modport master (
    output pmp_data, pmp_control, data_ready,
    input  data_accepted, pattern_accepted, busy,
    input  match_count
  );
  modport slave (
    input  pmp_data, pmp_control, data_ready,
    output data_accepted, pattern_accepted, busy,
    output match_count
  );
`else
  modport master (
    output pmp_data, pmp_control, data_ready,
    input  data_accepted, pattern_accepted, busy
  );
  modport slave (
    input  pmp_data, pmp_control, data_ready,
    output data_accepted, pattern_accepted, busy
  );
`endif
endinterface

// File: rtl/pmm_match_engine.sv
// Per-slot pattern-matching engine: LOAD/STREAM/CLEAR with a byte-serial scan.
// Optional match counter output enabled by PMM_MATCH_COUNT_EN.
module pmm_match_engine #(
  parameter int MAX_PAT_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  pmm_match_engine_if.slave pmp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD   = 2'd1;
  localparam logic [1:0] OP_STREAM = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;
  localparam logic [3:0] MAXC      = 4'(MAX_PAT_LEN);

  state_t state, nxt;

  logic [63:0] dat;
  logic [3:0]  cnt, idx;
  logic [3:0]  pat_len, fill, fill_n;
  logic        pa;
  logic [MAX_PAT_LEN-1:0][7:0] pat_rev;
  logic [MAX_PAT_LEN-1:0][7:0] hist, hist_n;
  logic [MAX_PAT_LEN-1:0][7:0] load_pat;
`ifdef PMM_MATCH_COUNT_EN
  logic [15:0] mc;
`endif

  logic [1:0] op_in;
  logic [3:0] cnt_raw, cnt_in;
  logic [7:0] cur_byte;
  logic       hit;
  logic       unused_ctrl;

  assign op_in       = pmp.pmp_control[15:14];
  assign cnt_raw     = pmp.pmp_control[13:10];
  assign cnt_in      = (cnt_raw > MAXC) ? MAXC : cnt_raw;
  assign unused_ctrl = ^pmp.pmp_control[9:0];
  assign cur_byte    = dat[{idx[2:0], 3'b000} +: 8];
  assign fill_n      = (fill == MAXC) ? fill : fill + 4'd1;

  // Pattern is kept reversed so pat_rev[i] lines up with hist[i].
  always_comb begin
    logic [2:0] src;
    load_pat = '0;
    src = '0;
    for (int i = 0; i < MAX_PAT_LEN; i++) begin
      src = 3'(cnt_in - 4'd1 - 4'(i));
      if (4'(i) < cnt_in)
        load_pat[i] = pmp.pmp_data[{src, 3'b000} +: 8];
    end
  end

  always_comb begin
    hist_n    = hist;
    hist_n[0] = cur_byte;
    for (int i = 1; i < MAX_PAT_LEN; i++)
      hist_n[i] = hist[i-1];
  end

  always_comb begin
    hit = (pat_len != 4'd0) && (fill_n >= pat_len);
    for (int i = 0; i < MAX_PAT_LEN; i++)
      if (4'(i) < pat_len && hist_n[i] != pat_rev[i])
        hit = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (pmp.data_ready)
          nxt = (op_in == OP_STREAM && cnt_in != 4'd0) ? SCAN : DONE;
      SCAN:
        if (idx + 4'd1 == cnt) nxt = DONE;
      DONE:
        if (!pmp.data_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    pmp.busy             = (state == SCAN);
    pmp.data_accepted    = (state == DONE);
    pmp.pattern_accepted = pa;
`ifdef PMM_MATCH_COUNT_EN
    pmp.match_count      = mc;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat     <= '0;
      cnt     <= '0;
      idx     <= '0;
      pat_rev <= '0;
      pat_len <= '0;
      hist    <= '0;
      fill    <= '0;
      pa      <= 1'b0;
`ifdef PMM_MATCH_COUNT_EN
      mc      <= '0;
`endif
    end else begin
      if (state == IDLE && pmp.data_ready) begin
        dat <= pmp.pmp_data;
        cnt <= cnt_in;
        idx <= '0;
        if (op_in == OP_LOAD) begin
          pat_rev <= load_pat;
          pat_len <= cnt_in;
        end
        if (op_in == OP_LOAD || op_in == OP_CLEAR) begin
          hist <= '0;
          fill <= '0;
          pa   <= 1'b0;
`ifdef PMM_MATCH_COUNT_EN
          mc   <= '0;
`endif
        end
      end else if (state == SCAN) begin
        hist <= hist_n;
        fill <= fill_n;
        idx  <= idx + 4'd1;
        if (hit) begin
          pa <= 1'b1;
`ifdef PMM_MATCH_COUNT_EN
          if (mc != 16'hFFFF) mc <= mc + 16'd1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pmm_match_engine.sv
// Directed bench for pmm_match_engine; match_count checks
// are active when PMM_MATCH_COUNT_EN is defined.
module tb_pmm_match_engine;

  logic clk;
  logic reset;
  int   vec;
  int   errs;

  pmm_match_engine_if bus ();

  pmm_match_engine #(.MAX_PAT_LEN(8)) dut (
    .clk   (clk),
    .reset (reset),
    .pmp   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(
    input  logic [15:0] c,
    input  logic [63:0] d,
    output int          lat,
    output int          nb,
    output int          pa_at,
    output logic        da_low
  );
    @(negedge clk);
    bus.pmp_control = c;
    bus.pmp_data    = d;
    bus.data_ready  = 1'b1;
    lat   = 0;
    nb    = 0;
    pa_at = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy === 1'b1) nb++;
      if (pa_at == 0 && bus.pattern_accepted === 1'b1) pa_at = lat;
    end while (bus.data_accepted !== 1'b1 && lat < 20);
    vec++;
    if (bus.data_accepted !== 1'b1) begin
      errs++;
      $display("FAIL op_timeout ctrl=%h got da=%b need 1", c, bus.data_accepted);
    end
    bus.data_ready  = 1'b0;
    bus.pmp_control = 16'h0000;
    @(posedge clk);
    #1;
    da_low = bus.data_accepted;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.data_ready  = 1'b0;
    bus.pmp_control = 16'h0;
    bus.pmp_data    = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (bus.data_accepted !== 1'b0 || bus.pattern_accepted !== 1'b0 ||
        bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_outputs got da=%b pa=%b busy=%b need 000",
               bus.data_accepted, bus.pattern_accepted, bus.busy);
    end
`ifdef PMM_MATCH_COUNT_EN
    vec++;
    if (bus.match_count !== 16'd0) begin
      errs++;
      $display("FAIL reset_mc got %0d need 0", bus.match_count);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load;
    int lat, nb, pa_at;
    logic da_low;
    run_op(16'h4800, 64'h4241, lat, nb, pa_at, da_low);
    vec++;
    if (lat !== 1) begin
      errs++;
      $display("FAIL load_latency got %0d need 1", lat);
    end
    vec++;
    if (pa_at !== 0) begin
      errs++;
      $display("FAIL load_pa got pa_at=%0d need 0", pa_at);
    end
    vec++;
    if (da_low !== 1'b0) begin
      errs++;
      $display("FAIL load_da_drop got %b need 0", da_low);
    end
  endtask

  task automatic test_stream;
    int lat, nb, pa_at;
    logic da_low;
    run_op(16'h9000, 64'h42417878, lat, nb, pa_at, da_low);
    vec++;
    if (nb !== 4) begin
      errs++;
      $display("FAIL stream_busy got %0d need 4", nb);
    end
    vec++;
    if (lat !== 5) begin
      errs++;
      $display("FAIL stream_latency got %0d need 5", lat);
    end
    vec++;
    if (pa_at !== 5) begin
      errs++;
      $display("FAIL stream_pa_edge got %0d need 5", pa_at);
    end
`ifdef PMM_MATCH_COUNT_EN
    vec++;
    if (bus.match_count !== 16'd1) begin
      errs++;
      $display("FAIL stream_mc got %0d need 1", bus.match_count);
    end
`endif
  endtask

  task automatic test_cross_word;
    int lat, nb, pa_at;
    logic da_low;
    run_op(16'hC000, 64'h0, lat, nb, pa_at, da_low);
    vec++;
    if (bus.pattern_accepted !== 1'b0) begin
      errs++;
      $display("FAIL cross_clear got %b need 0", bus.pattern_accepted);
    end
    run_op(16'h8800, 64'h417A, lat, nb, pa_at, da_low);
    vec++;
    if (pa_at !== 0) begin
      errs++;
      $display("FAIL cross_first got pa_at=%0d need 0", pa_at);
    end
    run_op(16'h8800, 64'h7A42, lat, nb, pa_at, da_low);
    vec++;
    if (pa_at !== 2) begin
      errs++;
      $display("FAIL cross_second got pa_at=%0d need 2", pa_at);
    end
`ifdef PMM_MATCH_COUNT_EN
    vec++;
    if (bus.match_count !== 16'd1) begin
      errs++;
      $display("FAIL cross_mc got %0d need 1", bus.match_count);
    end
`endif
  endtask

  task automatic test_overlap;
    int lat, nb, pa_at;
    logic da_low;
    run_op(16'h4800, 64'h4141, lat, nb, pa_at, da_low);
    run_op(16'h8C00, 64'h414141, lat, nb, pa_at, da_low);
    vec++;
    if (pa_at !== 3) begin
      errs++;
      $display("FAIL overlap_pa got pa_at=%0d need 3", pa_at);
    end
`ifdef PMM_MATCH_COUNT_EN
    vec++;
    if (bus.match_count !== 16'd2) begin
      errs++;
      $display("FAIL overlap_mc got %0d need 2", bus.match_count);
    end
`endif
    run_op(16'hC000, 64'h0, lat, nb, pa_at, da_low);
    vec++;
    if (bus.pattern_accepted !== 1'b0) begin
      errs++;
      $display("FAIL overlap_clear_pa got %b need 0", bus.pattern_accepted);
    end
`ifdef PMM_MATCH_COUNT_EN
    vec++;
    if (bus.match_count !== 16'd0) begin
      errs++;
      $display("FAIL overlap_clear_mc got %0d need 0", bus.match_count);
    end
`endif
    run_op(16'h8800, 64'h4141, lat, nb, pa_at, da_low);
    vec++;
    if (bus.pattern_accepted !== 1'b1) begin
      errs++;
      $display("FAIL overlap_retain got %b need 1", bus.pattern_accepted);
    end
  endtask

  task automatic test_clip;
    int lat, nb, pa_at;
    logic da_low;
    run_op(16'hB000, 64'h4141414141414141, lat, nb, pa_at, da_low);
    vec++;
    if (nb !== 8) begin
      errs++;
      $display("FAIL clip_busy got %0d need 8", nb);
    end
    vec++;
    if (lat !== 9) begin
      errs++;
      $display("FAIL clip_latency got %0d need 9", lat);
    end
`ifdef PMM_MATCH_COUNT_EN
    vec++;
    if (bus.match_count !== 16'd9) begin
      errs++;
      $display("FAIL clip_mc got %0d need 9", bus.match_count);
    end
`endif
  endtask

  task automatic test_zero_counts;
    int lat, nb, pa_at;
    logic da_low;
    run_op(16'h8000, 64'h4141, lat, nb, pa_at, da_low);
    vec++;
    if (lat !== 1 || nb !== 0) begin
      errs++;
      $display("FAIL zero_stream got lat=%0d busy=%0d need 1/0", lat, nb);
    end
    vec++;
    if (bus.pattern_accepted !== 1'b1) begin
      errs++;
      $display("FAIL zero_stream_pa got %b need 1", bus.pattern_accepted);
    end
    run_op(16'h4000, 64'h0, lat, nb, pa_at, da_low);
    run_op(16'h8800, 64'h0, lat, nb, pa_at, da_low);
    vec++;
    if (pa_at !== 0 || nb !== 2) begin
      errs++;
      $display("FAIL zero_load got pa_at=%0d busy=%0d need 0/2", pa_at, nb);
    end
`ifdef PMM_MATCH_COUNT_EN
    vec++;
    if (bus.match_count !== 16'd0) begin
      errs++;
      $display("FAIL zero_load_mc got %0d need 0", bus.match_count);
    end
`endif
  endtask

  task automatic test_async_reset;
    int lat, nb, pa_at;
    logic da_low;
    run_op(16'h4800, 64'h4241, lat, nb, pa_at, da_low);
    @(negedge clk);
    bus.pmp_control = 16'h9000;
    bus.pmp_data    = 64'h42417878;
    bus.data_ready  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    vec++;
    if (bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL ar_pre_busy got %b need 1", bus.busy);
    end
    reset = 1'b1;
    #1;
    vec++;
    if (bus.busy !== 1'b0 || bus.data_accepted !== 1'b0 ||
        bus.pattern_accepted !== 1'b0) begin
      errs++;
      $display("FAIL ar_outputs got busy=%b da=%b pa=%b need 000",
               bus.busy, bus.data_accepted, bus.pattern_accepted);
    end
    bus.data_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_op(16'h8800, 64'h4241, lat, nb, pa_at, da_low);
    vec++;
    if (pa_at !== 0 || nb !== 2) begin
      errs++;
      $display("FAIL ar_nomatch got pa_at=%0d busy=%0d need 0/2", pa_at, nb);
    end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    test_reset();
    test_load();
    test_stream();
    test_cross_word();
    test_overlap();
    test_clip();
    test_zero_counts();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
